mod_n_seq_checker: RTL and testbench

MOD_N_SEQ_CHECKER -- requirements
Module: mod_n_seq_checker

---
 rtl/mod_n_pkg.sv | 13 +
 rtl/mod_n_next.sv | 12 +
 rtl/mod_n_seq_checker.sv | 116 +++++++++++
 tb/tb_mod_n_seq_checker.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mod_n_pkg.sv
// Shared types and default thresholds for the mod-N sequence checker.
package mod_n_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam int LOCK_CNT_DEF   = 4;
    localparam int UNLOCK_CNT_DEF = 3;

endpackage

// File: rtl/mod_n_next.sv
// Combinational successor in the mod-N counter sequence: N-1 wraps to 0.
module mod_n_next #(
    parameter int N     = 256,
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);

    assign y = (x == WIDTH'(N - 1)) ? '0 : x + WIDTH'(1);

endmodule

// File: rtl/mod_n_seq_checker.sv
// Locks onto a free-running mod-N counter stream and flags mismatches once locked.
// One-cycle latency from sampling edge to flags/state; always accepts input, no backpressure.
module mod_n_seq_checker
    import mod_n_pkg::*;
#(
    parameter int N          = 256,
    parameter int WIDTH      = 32,
    parameter int LOCK_CNT   = LOCK_CNT_DEF,
    parameter int UNLOCK_CNT = UNLOCK_CNT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic             oor_pulse,
    output logic [15:0]      err_count,
    output logic [WIDTH-1:0] expected
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int UW = $clog2(UNLOCK_CNT + 1);
    localparam logic [WIDTH-1:0] N_W = WIDTH'(N);

    state_t          state, state_nxt;
    logic [MW-1:0]   match_cnt;
    logic [UW-1:0]   miss_cnt;
    logic [WIDTH-1:0] next_in, next_exp;
    logic            in_range, hit, last_match, last_miss, err_inc;

    mod_n_next #(.N(N), .WIDTH(WIDTH)) u_next_in  (.x(in_data),  .y(next_in));
    mod_n_next #(.N(N), .WIDTH(WIDTH)) u_next_exp (.x(expected), .y(next_exp));

    assign in_range   = in_data < N_W;
    assign hit        = in_data == expected;
    assign last_match = match_cnt == MW'(LOCK_CNT - 1);
    assign last_miss  = miss_cnt == UW'(UNLOCK_CNT - 1);
    assign err_inc    = in_valid && (state == ST_LOCKED) && !hit;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_SEARCH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (in_valid) begin
            case (state)
                ST_SEARCH: if (in_range) state_nxt = ST_SYNC;
                ST_SYNC: begin
                    if (hit && last_match) state_nxt = ST_LOCKED;
                    else if (!in_range)    state_nxt = ST_SEARCH;
                end
                ST_LOCKED: if (!hit && last_miss) state_nxt = ST_SEARCH;
                default:   state_nxt = ST_SEARCH;
            endcase
        end
    end

    always_comb begin
        locked = (state == ST_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            expected  <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            err_count <= '0;
            err_pulse <= 1'b0;
            oor_pulse <= 1'b0;
        end else begin
            err_pulse <= err_inc;
            oor_pulse <= in_valid && !in_range;
            if (in_valid) begin
                case (state)
                    ST_SEARCH: begin
                        if (in_range) begin
                            expected  <= next_in;
                            match_cnt <= MW'(1);
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    ST_SYNC: begin
                        if (hit) begin
                            expected  <= next_exp;
                            match_cnt <= match_cnt + MW'(1);
                            miss_cnt  <= '0;
                        end else if (in_range) begin
                            expected  <= next_in;
                            match_cnt <= MW'(1);
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        // Flywheel: keep predicting through misses so a single glitch doesn't cost lock.
                        expected <= next_exp;
                        if (hit)            miss_cnt <= '0;
                        else if (last_miss) miss_cnt <= '0;
                        else                miss_cnt <= miss_cnt + UW'(1);
                    end
                    default: ;
                endcase
            end
            if (clr_err)
                err_count <= '0;
            else if (err_inc && err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_mod_n_seq_checker.sv
// Scoreboarded bench: a reference model pushes expected outputs per driven cycle, popped after the edge.
module tb_mod_n_seq_checker;

    localparam int N = 256;

    logic        clk = 1'b0;
    logic        rst, in_valid, clr_err;
    logic [31:0] in_data;
    logic        locked, err_pulse, oor_pulse;
    logic [15:0] err_count;
    logic [31:0] expected;

    mod_n_seq_checker dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_err(clr_err),
        .locked(locked), .err_pulse(err_pulse), .oor_pulse(oor_pulse),
        .err_count(err_count), .expected(expected)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        locked;
        logic        err;
        logic        oor;
        logic [15:0] cnt;
        logic [31:0] exp;
    } obs_t;

    obs_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state: 0 = search, 1 = sync, 2 = locked.
    int          m_state = 0;
    int          m_match = 0;
    int          m_miss  = 0;
    logic [31:0] m_exp   = 0;
    logic [15:0] m_cnt   = 0;

    function automatic logic [31:0] nx(logic [31:0] x);
        return (x == N - 1) ? 32'd0 : x + 32'd1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0d, want %0d at %0t", tag, got, want, $time);
    endtask

    task automatic model_step(input logic r, input logic v, input logic [31:0] d, input logic c);
        obs_t o;
        o.err = 1'b0;
        o.oor = 1'b0;
        if (r) begin
            m_state = 0; m_match = 0; m_miss = 0; m_exp = 0; m_cnt = 0;
        end else begin
            if (v) begin
                o.oor = (d >= N);
                case (m_state)
                    0: begin
                        if (d < N) begin m_exp = nx(d); m_match = 1; m_state = 1; end
                        else m_match = 0;
                    end
                    1: begin
                        if (d == m_exp) begin
                            m_exp = nx(m_exp);
                            m_match++;
                            if (m_match == 4) begin m_state = 2; m_miss = 0; end
                        end else if (d < N) begin
                            m_exp = nx(d); m_match = 1;
                        end else begin
                            m_state = 0; m_match = 0;
                        end
                    end
                    default: begin
                        if (d == m_exp) m_miss = 0;
                        else begin
                            o.err = 1'b1;
                            if (m_cnt != 16'hFFFF) m_cnt++;
                            m_miss++;
                            if (m_miss == 3) begin m_state = 0; m_miss = 0; end
                        end
                        m_exp = nx(m_exp);
                    end
                endcase
            end
            if (c) m_cnt = 0;
        end
        o.locked = (m_state == 2);
        o.cnt    = m_cnt;
        o.exp    = m_exp;
        sb.push_back(o);
    endtask

    task automatic cycle(input logic r, input logic v, input logic [31:0] d, input logic c);
        obs_t e;
        rst = r; in_valid = v; in_data = d; clr_err = c;
        model_step(r, v, d, c);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("locked",    locked,    e.locked);
        check("err_pulse", err_pulse, e.err);
        check("oor_pulse", oor_pulse, e.oor);
        check("err_count", err_count, e.cnt);
        check("expected",  expected,  e.exp);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_data = 32'd77; clr_err = 1'b0;

        // Reset overrides a valid input.
        cycle(1, 1, 77, 0);
        check("rst_locked", locked, 0);
        check("rst_expected", expected, 0);

        // Lock on 10..13.
        for (int i = 10; i <= 13; i++) cycle(0, 1, i, 0);
        check("lock4_locked", locked, 1);
        check("lock4_expected", expected, 14);
        check("lock4_errcnt", err_count, 0);

        // Run through the wrap 254,255,0,1.
        for (int i = 14; i <= 257; i++) cycle(0, 1, i % 256, 0);
        check("wrap_expected", expected, 2);
        check("wrap_errcnt", err_count, 0);

        // Single glitch while locked.
        for (int i = 2; i <= 49; i++) cycle(0, 1, i, 0);
        cycle(0, 1, 50, 0);
        cycle(0, 1, 99, 0);
        check("glitch_pulse", err_pulse, 1);
        cycle(0, 1, 52, 0);
        check("glitch_errcnt", err_count, 1);
        check("glitch_locked", locked, 1);
        check("glitch_expected", expected, 53);

        // Idle cycles with junk data change nothing; clear the counter.
        for (int i = 53; i <= 275; i++) cycle(0, 1, i % 256, 0);
        cycle(0, 0, 1234, 0);
        cycle(0, 0, 7, 1);
        check("idle_expected", expected, 20);
        check("clr_errcnt", err_count, 0);

        // Three consecutive misses drop lock.
        for (int i = 0; i < 3; i++) cycle(0, 1, 7, 0);
        check("unlock_errcnt", err_count, 3);
        check("unlock_locked", locked, 0);

        // Out-of-range in SYNC.
        cycle(0, 1, 40, 0);
        cycle(0, 1, 41, 0);
        cycle(0, 1, 300, 0);
        check("oor_pulse", oor_pulse, 1);
        check("oor_errcnt", err_count, 3);
        cycle(0, 1, 42, 0);
        check("oor_search_nolock", locked, 0);

        // Clear wins against a simultaneous error.
        for (int i = 60; i <= 63; i++) cycle(0, 1, i, 0);
        cycle(0, 1, 5, 1);
        check("clrwin_pulse", err_pulse, 1);
        check("clrwin_errcnt", err_count, 0);

        // Reset while locked, then relock needs a full fresh run.
        cycle(1, 1, 65, 0);
        check("midrst_locked", locked, 0);
        for (int i = 100; i <= 102; i++) cycle(0, 1, i, 0);
        check("relock_early", locked, 0);
        cycle(0, 1, 103, 0);
        check("relock_done", locked, 1);

        // Random mix: mostly in sequence, some junk, gaps and clears.
        for (int i = 0; i < 600; i++) begin
            logic        v, c;
            logic [31:0] d;
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 19) == 0);
            d = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 299)) : m_exp;
            cycle(0, v, d, c);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
